// File: rtl/conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl
// Description : Sequencer for the 3x3 convolution datapath. Reads a 3x3
//               weight set and an IMG_W x IMG_H image from a single-port read
//               memory (1-cycle read latency). It loads the weights once per
//               job, then presents each valid 3x3 window to the datapath in
//               raster order and returns one result per window over a
//               valid/ready stream.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, busy, done - job request / job active / end-of-job pulse
//               mem_rd, mem_addr,
//               mem_rdata         - read port, data valid 1 cycle after mem_rd
//               conv_w_w,
//               conv_if_w         - datapath weight / input write strobes
//               conv_w_data,
//               conv_if_data      - 9 weight / 9 input lanes, tap k at [k*DW +: DW]
//               conv_out          - signed datapath sum (2*DW+1 bits)
//               res_valid,
//               res_ready,
//               res_data,
//               res_x, res_y      - result stream with window origin
//
// Config      : CONV_CTRL_RELU_EN - when defined, negative sums are clamped
//                                   to zero before they reach res_data.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 12,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int WBASE = 0,
    parameter int IBASE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic              conv_w_w,
    output logic              conv_if_w,
    output logic [9*DW-1:0]   conv_w_data,
    output logic [9*DW-1:0]   conv_if_data,
    input  logic [2*DW:0]     conv_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*DW:0]     res_data,
    output logic [7:0]        res_x,
    output logic [7:0]        res_y
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_W_COMMIT = 3'd2,
        S_FETCH    = 3'd3,
        S_FIRE     = 3'd4,
        S_SAMPLE   = 3'd5,
        S_EMIT     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [7:0] C_X_LAST   = 8'(IMG_W - 3);
    localparam logic [7:0] C_Y_LAST   = 8'(IMG_H - 3);
    // A 9-tap burst: reads issued while cnt is 0..8, data captured while cnt is 1..9.
    localparam logic [3:0] C_LAST_RD  = 4'd8;
    localparam logic [3:0] C_LAST_CAP = 4'd9;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic               r_busy;
    logic               r_done;
    logic               r_mem_rd;
    logic [AW-1:0]      r_mem_addr;
    logic               r_conv_w_w;
    logic               r_conv_if_w;
    logic [9*DW-1:0]    r_w_stage;
    logic [9*DW-1:0]    r_if_stage;
    logic               r_res_valid;
    logic [2*DW:0]      r_res_data;
    logic [7:0]         r_res_x;
    logic [7:0]         r_res_y;

    logic               w_x_wrap;
    logic               w_last_win;
    logic [7:0]         w_nx;
    logic [7:0]         w_ny;
    logic [3:0]         w_cnt_nxt;
    logic [2*DW:0]      w_sample;

    // Address of tap k of the window whose top-left pixel is (px, py).
    function automatic logic [AW-1:0] f_pix_addr(input logic [7:0] px,
                                                 input logic [7:0] py,
                                                 input logic [3:0] tap);
        int row;
        int col;
        row = (tap >= 4'd6) ? 2 : ((tap >= 4'd3) ? 1 : 0);
        col = int'(tap) - 3 * row;
        return AW'(IBASE + (int'(py) + row) * IMG_W + int'(px) + col);
    endfunction

    function automatic logic [AW-1:0] f_w_addr(input logic [3:0] tap);
        return AW'(WBASE + int'(tap));
    endfunction

    always_comb begin
        w_x_wrap   = (r_x == C_X_LAST);
        w_last_win = w_x_wrap && (r_y == C_Y_LAST);
        w_nx       = w_x_wrap ? 8'd0 : r_x + 8'd1;
        w_ny       = w_x_wrap ? r_y + 8'd1 : r_y;
        w_cnt_nxt  = r_cnt + 4'd1;
`ifdef CONV_CTRL_RELU_EN
        w_sample   = conv_out[2*DW] ? '0 : conv_out;
`else
        w_sample   = conv_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_conv_w_w  <= 1'b0;
            r_conv_if_w <= 1'b0;
            r_w_stage   <= '0;
            r_if_stage  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD_W;
                        r_busy     <= 1'b1;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_cnt      <= '0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= f_w_addr(4'd0);
                    end
                end

                S_LOAD_W, S_FETCH: begin
                    // Staging banks are shift registers: after nine captures
                    // tap 0 has reached lane 0 and tap 8 sits in lane 8.
                    if (r_cnt != 4'd0) begin
                        if (r_state == S_LOAD_W) begin
                            r_w_stage <= {mem_rdata, r_w_stage[9*DW-1:DW]};
                        end else begin
                            r_if_stage <= {mem_rdata, r_if_stage[9*DW-1:DW]};
                        end
                    end
                    if (r_cnt < C_LAST_RD) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= (r_state == S_LOAD_W) ? f_w_addr(w_cnt_nxt)
                                                            : f_pix_addr(r_x, r_y, w_cnt_nxt);
                    end else begin
                        r_mem_rd <= 1'b0;
                    end
                    if (r_cnt == C_LAST_CAP) begin
                        r_cnt <= '0;
                        if (r_state == S_LOAD_W) begin
                            r_state    <= S_W_COMMIT;
                            r_conv_w_w <= 1'b1;
                        end else begin
                            r_state     <= S_FIRE;
                            r_conv_if_w <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end

                S_W_COMMIT: begin
                    r_conv_w_w <= 1'b0;
                    r_state    <= S_FETCH;
                    r_cnt      <= '0;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= f_pix_addr(r_x, r_y, 4'd0);
                end

                S_FIRE: begin
                    r_conv_if_w <= 1'b0;
                    r_state     <= S_SAMPLE;
                end

                S_SAMPLE: begin
                    // The datapath registered its inputs on the FIRE edge, so
                    // conv_out reflects the current window in this cycle.
                    r_res_data  <= w_sample;
                    r_res_x     <= r_x;
                    r_res_y     <= r_y;
                    r_res_valid <= 1'b1;
                    r_state     <= S_EMIT;
                end

                S_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_last_win) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_x        <= w_nx;
                            r_y        <= w_ny;
                            r_state    <= S_FETCH;
                            r_cnt      <= '0;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= f_pix_addr(w_nx, w_ny, 4'd0);
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not sampled here.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_rd       = r_mem_rd;
    assign mem_addr     = r_mem_addr;
    assign conv_w_w     = r_conv_w_w;
    assign conv_if_w    = r_conv_if_w;
    assign conv_w_data  = r_w_stage;
    assign conv_if_data = r_if_stage;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_x        = r_res_x;
    assign res_y        = r_res_y;

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_ctrl
// Description : Self-checking bench for conv_ctrl on a 4x4 image. Provides a
//               1-cycle-latency memory and a behavioural 3x3 MAC datapath;
//               expected results are computed directly from memory contents
//               as window sums in raster order, and pinned by literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_ctrl;

    localparam int DW      = 8;
    localparam int AW      = 12;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int WBASE   = 0;
    localparam int IBASE   = 16;
    localparam int NRES    = (IMG_W - 2) * (IMG_H - 2);
    localparam int TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic              conv_w_w;
    logic              conv_if_w;
    logic [9*DW-1:0]   conv_w_data;
    logic [9*DW-1:0]   conv_if_data;
    logic [2*DW:0]     conv_out;
    logic              res_valid;
    logic              res_ready;
    logic [2*DW:0]     res_data;
    logic [7:0]        res_x;
    logic [7:0]        res_y;

    always #5 clk = ~clk;

    conv_ctrl #(
        .DW    (DW),
        .AW    (AW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WBASE (WBASE),
        .IBASE (IBASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .conv_w_w     (conv_w_w),
        .conv_if_w    (conv_if_w),
        .conv_w_data  (conv_w_data),
        .conv_if_data (conv_if_data),
        .conv_out     (conv_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_x        (res_x),
        .res_y        (res_y)
    );

    // ---------------- memory and datapath models ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    logic [9*DW-1:0] dp_w = '0;
    logic [9*DW-1:0] dp_i = '0;
    int              dp_sum;
    always @(posedge clk) begin
        if (conv_w_w)  dp_w <= conv_w_data;
        if (conv_if_w) dp_i <= conv_if_data;
    end
    always_comb begin
        dp_sum = 0;
        for (int k = 0; k < 9; k++)
            dp_sum += int'($signed(dp_w[k*DW +: DW])) * int'($signed(dp_i[k*DW +: DW]));
        conv_out = dp_sum[2*DW:0];
    end

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    typedef struct {
        longint data;
        int     x;
        int     y;
    } res_t;

    res_t   exp_q[$];
    longint lit_q[$];

    // Window sums straight from memory contents, in raster order.
    task automatic build_expected();
        longint s;
        res_t   e;
        exp_q.delete();
        for (int y = 0; y <= IMG_H - 3; y++) begin
            for (int x = 0; x <= IMG_W - 3; x++) begin
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        s += longint'($signed(mem[WBASE + 3*r + c])) *
                             longint'($signed(mem[IBASE + (y + r)*IMG_W + x + c]));
`ifdef CONV_CTRL_RELU_EN
                if (s < 0) s = 0;
`endif
                e.data = s;
                e.x    = x;
                e.y    = y;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_mem(input int w);
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        for (int k = 0; k < 9; k++) mem[WBASE + k] = w[DW-1:0];
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                mem[IBASE + y*IMG_W + x] = DW'(4*y + x);
    endtask

    // ---------------- ready driver ----------------
    bit stall_mode = 1'b0;
    int stall_cnt  = 0;
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                res_ready = 1'b1;
            end else if (res_valid) begin
                if (stall_cnt >= 5) res_ready = 1'b1;
                else begin
                    res_ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                res_ready = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    bit            job_on   = 1'b0;
    bit            job_done = 1'b0;
    int            t0, jc;
    int            first_ww, n_ww, first_ifw, n_ifw, n_rd_early, n_rd;
    int            n_hs, last_hs, n_done;
    int            rise_q[$];
    logic          prev_valid, prev_ready;
    logic [2*DW:0] prev_data;
    logic [7:0]    prev_x, prev_y;
    res_t          mon_e;

    always @(negedge clk) begin
        if (job_on && !rst) begin
            jc = cyc - t0;
            if (!job_done) check("busy_in_job", busy, 1);
            if (conv_w_w) begin
                n_ww++;
                if (first_ww < 0) first_ww = jc;
            end
            if (conv_if_w) begin
                n_ifw++;
                if (first_ifw < 0) first_ifw = jc;
            end
            if (mem_rd) begin
                n_rd++;
                if (jc <= 22) n_rd_early++;
            end
            if (res_valid && !prev_valid) rise_q.push_back(jc);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", $signed(res_data), $signed(prev_data));
                check("hold_x", res_x, prev_x);
                check("hold_y", res_y, prev_y);
            end
            if (res_valid && res_ready) begin
                n_hs++;
                last_hs = jc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_result: got %0d at (%0d,%0d), expected none",
                             $signed(res_data), res_x, res_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_data", $signed(res_data), mon_e.data);
                    check("res_x", res_x, mon_e.x);
                    check("res_y", res_y, mon_e.y);
                end
                if (lit_q.size() != 0)
                    check("res_data_literal", $signed(res_data), lit_q.pop_front());
            end
            if (done) begin
                n_done++;
                job_done = 1'b1;
                check("done_cycle", jc, last_hs + 1);
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_x     = res_x;
            prev_y     = res_y;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_zero(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mem_rd"},    mem_rd, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_w_w"},       conv_w_w, 0);
        check({tag, "_if_w"},      conv_if_w, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data, 0);
        check({tag, "_res_x"},     res_x, 0);
        check({tag, "_res_y"},     res_y, 0);
        check({tag, "_w_lanes"},   |conv_w_data, 0);
        check({tag, "_if_lanes"},  |conv_if_data, 0);
    endtask

    task automatic run_job(input int pulse_cyc, input int rst_cyc, input bit stall);
        int jcm;
        bit finished;
        stall_mode = stall;
        build_expected();
        first_ww = -1; n_ww = 0; first_ifw = -1; n_ifw = 0;
        n_rd_early = 0; n_rd = 0; n_hs = 0; last_hs = -100; n_done = 0;
        rise_q.delete();
        prev_valid = 1'b0; prev_ready = 1'b0;
        job_done = 1'b0;
        @(negedge clk);
        #1;
        start  = 1'b1;
        t0     = cyc;
        job_on = 1'b1;
        finished = 1'b0;
        for (int k = 0; k < TIMEOUT && !finished; k++) begin
            @(negedge clk);
            #1;
            jcm   = cyc - t0;
            start = (jcm == pulse_cyc);
            if (jcm == rst_cyc) begin
                rst = 1'b1;
            end else if (rst) begin
                check_zero("mid_rst");
                rst = 1'b0;
                finished = 1'b1;
            end
            if (job_done) finished = 1'b1;
        end
        job_on = 1'b0;
        start  = 1'b0;
        if (!finished) begin
            n_chk++;
            n_fail++;
            $display("FAIL job_timeout: got no done within %0d cycles, expected done", TIMEOUT);
        end
        if (rst_cyc < 0) begin
            check("n_results", n_hs, NRES);
            check("pending_results", exp_q.size(), 0);
            check("pending_literals", lit_q.size(), 0);
            check("n_done", n_done, 1);
            @(negedge clk);
            #1;
            check("done_width", done, 0);
            check("idle_busy", busy, 0);
        end else begin
            check("rst_no_result", n_hs, 0);
            exp_q.delete();
            lit_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_timing();
        check("w_w_cycle", first_ww, 11);
        check("w_w_count", n_ww, 1);
        check("if_w_cycle", first_ifw, 22);
        check("if_w_count", n_ifw, NRES);
        check("rd_count_first_22", n_rd_early, 18);
        check("rd_count_total", n_rd, 9 + 9*NRES);
        check("valid_rises", rise_q.size(), NRES);
        if (rise_q.size() >= 2) begin
            check("valid1_cycle", rise_q[0], 24);
            check("valid2_cycle", rise_q[1], 37);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load_mem(1);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", busy, 0);

        // weights 1, ready tied high, plus cycle checks
        lit_q = {45, 54, 81, 90};
        run_job(-1, -1, 1'b0);
        check_timing();

        // 5-cycle back-pressure at every result
        lit_q = {45, 54, 81, 90};
        run_job(-1, -1, 1'b1);

        // weights -1
        load_mem(-1);
`ifdef CONV_CTRL_RELU_EN
        lit_q = {0, 0, 0, 0};
`else
        lit_q = {-45, -54, -81, -90};
`endif
        run_job(-1, -1, 1'b0);

        // start pulsed mid-job must be ignored
        load_mem(1);
        lit_q = {45, 54, 81, 90};
        run_job(15, -1, 1'b0);

        // reset mid-FETCH
        lit_q.delete();
        run_job(-1, 16, 1'b0);

        // a fresh job after the abort reproduces the first one
        lit_q = {45, 54, 81, 90};
        run_job(-1, -1, 1'b0);
        check_timing();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
